// File: rtl/sd_spi_card_responder.sv
// rtl/sd_spi_card_responder.sv - SPI-mode SD card responder (optional CRC7 check: SD_CRC7_CHECK_EN)
module sd_spi_card_responder #(
  parameter int BLK_W      = 4,
  parameter int INIT_POLLS = 3,
  parameter int NAC_BYTES  = 2,
  parameter int BUSY_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spi_cs_n,
  input  logic             spi_clk,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [BLK_W+8:0] mem_addr,
  input  logic [7:0]       mem_rdata,
  output logic [7:0]       mem_wdata,
  output logic             mem_we,
  output logic             card_ready,
  output logic [5:0]       cmd_index
);

  localparam logic [7:0] INIT_POLLS_C = 8'(INIT_POLLS);
  localparam logic [7:0] NAC_LAST     = 8'(NAC_BYTES - 1);
  localparam logic [7:0] BUSY_LAST    = 8'(BUSY_BYTES - 1);

  typedef enum logic [3:0] {
    HUNT, CMD_RX, NCR, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
    WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
  } state_t;

  // synchronizer and edge-detect registers
  logic cs_meta_q, cs_sync_q;
  logic sck_meta_q, sck_sync_q, sck_prev_q;
  logic mosi_meta_q, mosi_sync_q;

  // bit-level shifter registers
  logic [2:0] bit_cnt_q;
  logic [6:0] rx_sr_q;
  logic [6:0] tx_sr_q;
  logic       miso_q;

  // protocol FSM registers
  state_t           state_q;
  logic [7:0]       cnt_q;
  logic [8:0]       idx_q;
  logic [BLK_W-1:0] blk_q;
  logic [5:0]       cmd_q;
  logic [31:0]      arg_q;
  logic [39:0]      resp_q;
  logic [2:0]       resp_len_q;
  logic             rd_go_q, wr_go_q;
  logic             app_q;
  logic [7:0]       polls_q;
  logic             ready_q;
  logic [5:0]       cmd_index_q;
  logic [7:0]       tx_next_q;
  logic             tx_sel_mem_q;
  logic [BLK_W+8:0] mem_addr_q;
  logic [7:0]       mem_wdata_q;
  logic             mem_we_q;
`ifdef SD_CRC7_CHECK_EN
  logic [6:0]       crc_q;

  function automatic logic [6:0] crc7_upd(input logic [6:0] c, input logic [7:0] b);
    logic [6:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[6] ^ b[i];
      r  = {r[5:0], 1'b0};
      if (fb) r = r ^ 7'h09;
    end
    return r;
  endfunction
`endif

  logic       sck_rise, sck_fall, rx_done;
  logic [7:0] rx_byte, tx_load, idle8;
  logic [8:0] idx_inc;

  assign sck_rise = sck_sync_q & ~sck_prev_q & ~cs_sync_q;
  assign sck_fall = ~sck_sync_q & sck_prev_q & ~cs_sync_q;
  assign rx_done  = sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte  = {rx_sr_q, mosi_sync_q};
  assign tx_load  = tx_sel_mem_q ? mem_rdata : tx_next_q;
  assign idle8    = {7'd0, ~ready_q};
  assign idx_inc  = idx_q + 9'd1;

  // two-flop synchronizers for the SPI pins plus previous-clock sample for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      mosi_meta_q <= 1'b1;
      mosi_sync_q <= 1'b1;
    end else begin
      cs_meta_q   <= spi_cs_n;
      cs_sync_q   <= cs_meta_q;
      sck_meta_q  <= spi_clk;
      sck_sync_q  <= sck_meta_q;
      sck_prev_q  <= sck_sync_q;
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  // mode-0 shifter: sample MOSI on rising edge, drive MISO on falling edge, new byte at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 3'd0;
      rx_sr_q   <= 7'd0;
      tx_sr_q   <= 7'h7F;
      miso_q    <= 1'b1;
    end else if (cs_sync_q) begin
      bit_cnt_q <= 3'd0;
      tx_sr_q   <= 7'h7F;
      miso_q    <= 1'b1;
    end else begin
      if (sck_rise) begin
        rx_sr_q   <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (sck_fall) begin
        if (bit_cnt_q == 3'd0) begin
          miso_q  <= tx_load[7];
          tx_sr_q <= tx_load[6:0];
        end else begin
          miso_q  <= tx_sr_q[6];
          tx_sr_q <= {tx_sr_q[5:0], 1'b1};
        end
      end
    end
  end

  // command decode: response bytes and card-state updates for the frame just received
  logic [39:0] dec_resp;
  logic [2:0]  dec_len;
  logic        dec_rd, dec_wr, dec_ready, dec_app, arg_oob;
  logic [7:0]  dec_polls;

  always_comb begin
    dec_resp  = {idle8, 32'd0};
    dec_len   = 3'd1;
    dec_rd    = 1'b0;
    dec_wr    = 1'b0;
    dec_ready = ready_q;
    dec_polls = polls_q;
    dec_app   = (cmd_q == 6'd55);
    arg_oob   = (arg_q >> BLK_W) != 32'd0;
    case (cmd_q)
      6'd0: begin
        dec_resp[39:32] = 8'h01;
        dec_ready       = 1'b0;
        dec_polls       = 8'd0;
      end
      6'd8: begin
        dec_resp = {8'h01, 8'h00, 8'h00, 4'h0, arg_q[11:8], arg_q[7:0]};
        dec_len  = 3'd5;
      end
      6'd55: ;
      6'd41: begin
        if (!app_q) begin
          dec_resp[39:32] = 8'h04 | idle8;
        end else if (polls_q < INIT_POLLS_C) begin
          dec_polls       = polls_q + 8'd1;
          dec_resp[39:32] = 8'h01;
        end else begin
          dec_resp[39:32] = 8'h00;
          dec_ready       = 1'b1;
        end
      end
      6'd58: begin
        dec_resp = {idle8, 32'hC0FF_8000};
        dec_len  = 3'd5;
      end
      6'd17, 6'd24: begin
        if (!ready_q) begin
          dec_resp[39:32] = 8'h05;
        end else if (arg_oob) begin
          dec_resp[39:32] = 8'h40;
        end else begin
          dec_resp[39:32] = 8'h00;
          dec_rd          = (cmd_q == 6'd17);
          dec_wr          = (cmd_q == 6'd24);
        end
      end
      default: dec_resp[39:32] = 8'h04 | idle8;
    endcase
  end

  // byte-level protocol FSM: each received byte decides the contents of the next MISO slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HUNT;
      cnt_q        <= 8'd0;
      idx_q        <= 9'd0;
      blk_q        <= '0;
      cmd_q        <= 6'd0;
      arg_q        <= 32'd0;
      resp_q       <= 40'd0;
      resp_len_q   <= 3'd0;
      rd_go_q      <= 1'b0;
      wr_go_q      <= 1'b0;
      app_q        <= 1'b0;
      polls_q      <= 8'd0;
      ready_q      <= 1'b0;
      cmd_index_q  <= 6'd0;
      tx_next_q    <= 8'hFF;
      tx_sel_mem_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'd0;
      mem_we_q     <= 1'b0;
`ifdef SD_CRC7_CHECK_EN
      crc_q        <= 7'd0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      if (cs_sync_q) begin
        state_q      <= HUNT;
        tx_next_q    <= 8'hFF;
        tx_sel_mem_q <= 1'b0;
      end else if (rx_done) begin
        tx_next_q <= 8'hFF;
        case (state_q)
          HUNT: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_q   <= rx_byte[5:0];
              cnt_q   <= 8'd0;
              state_q <= CMD_RX;
`ifdef SD_CRC7_CHECK_EN
              crc_q   <= crc7_upd(7'd0, rx_byte);
`endif
            end
          end
          CMD_RX: begin
            if (cnt_q == 8'd4) begin
              state_q <= NCR;
`ifdef SD_CRC7_CHECK_EN
              if (crc_q != rx_byte[7:1]) begin
                resp_q     <= {8'h08 | idle8, 32'd0};
                resp_len_q <= 3'd1;
                rd_go_q    <= 1'b0;
                wr_go_q    <= 1'b0;
              end else
`endif
              begin
                resp_q      <= dec_resp;
                resp_len_q  <= dec_len;
                rd_go_q     <= dec_rd;
                wr_go_q     <= dec_wr;
                ready_q     <= dec_ready;
                polls_q     <= dec_polls;
                app_q       <= dec_app;
                cmd_index_q <= cmd_q;
                blk_q       <= arg_q[BLK_W-1:0];
              end
            end else begin
              arg_q <= {arg_q[23:0], rx_byte};
              cnt_q <= cnt_q + 8'd1;
`ifdef SD_CRC7_CHECK_EN
              crc_q <= crc7_upd(crc_q, rx_byte);
`endif
            end
          end
          NCR: begin
            tx_next_q <= resp_q[39:32];
            resp_q    <= {resp_q[31:0], 8'd0};
            cnt_q     <= 8'd1;
            state_q   <= RESP;
          end
          RESP: begin
            if (cnt_q < 8'(resp_len_q)) begin
              tx_next_q <= resp_q[39:32];
              resp_q    <= {resp_q[31:0], 8'd0};
              cnt_q     <= cnt_q + 8'd1;
            end else if (rd_go_q) begin
              cnt_q <= 8'd0;
              if (NAC_BYTES == 0) begin
                tx_next_q <= 8'hFE;
                state_q   <= RD_TOKEN;
              end else begin
                state_q <= RD_GAP;
              end
            end else if (wr_go_q) begin
              state_q <= WR_TOKEN;
            end else begin
              state_q <= HUNT;
            end
          end
          RD_GAP: begin
            if (cnt_q == NAC_LAST) begin
              tx_next_q <= 8'hFE;
              state_q   <= RD_TOKEN;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          RD_TOKEN: begin
            tx_sel_mem_q <= 1'b1;
            mem_addr_q   <= {blk_q, 9'd0};
            idx_q        <= 9'd0;
            state_q      <= RD_DATA;
          end
          RD_DATA: begin
            if (idx_q == 9'd511) begin
              tx_sel_mem_q <= 1'b0;
              cnt_q        <= 8'd0;
              state_q      <= RD_CRC;
            end else begin
              idx_q      <= idx_inc;
              mem_addr_q <= {blk_q, idx_inc};
            end
          end
          RD_CRC: begin
            if (cnt_q == 8'd1) state_q <= HUNT;
            else               cnt_q   <= 8'd1;
          end
          WR_TOKEN: begin
            if (rx_byte == 8'hFE) begin
              idx_q   <= 9'd0;
              state_q <= WR_DATA;
            end
          end
          WR_DATA: begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= {blk_q, idx_q};
            mem_wdata_q <= rx_byte;
            if (idx_q == 9'd511) begin
              cnt_q   <= 8'd0;
              state_q <= WR_CRC;
            end else begin
              idx_q <= idx_inc;
            end
          end
          WR_CRC: begin
            if (cnt_q == 8'd1) begin
              tx_next_q <= 8'h05;
              state_q   <= WR_RESP;
            end else begin
              cnt_q <= 8'd1;
            end
          end
          WR_RESP: begin
            if (BUSY_BYTES == 0) begin
              state_q <= HUNT;
            end else begin
              tx_next_q <= 8'h00;
              cnt_q     <= 8'd0;
              state_q   <= WR_BUSY;
            end
          end
          WR_BUSY: begin
            if (cnt_q == BUSY_LAST) begin
              state_q <= HUNT;
            end else begin
              tx_next_q <= 8'h00;
              cnt_q     <= cnt_q + 8'd1;
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign spi_miso   = miso_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign card_ready = ready_q;
  assign cmd_index  = cmd_index_q;

endmodule

// File: doc/sd_spi_card_responder.md
Name: sd_spi_card_responder

Overview:
Synthesizable SPI-mode SD card responder: the card end of the SPI link driven by the SD host controller. It decodes 48-bit command frames, returns R1/R3/R7 responses, serves single-block reads (CMD17) and accepts single-block writes (CMD24) against an external byte-wide memory. It is used as a bench and FPGA loopback target for the host controller, with no physical card required.

Parameters:
BLK_W, 4, block-address width; the card holds 2^BLK_W blocks of 512 bytes.
INIT_POLLS, 3, number of ACMD41 commands answered 0x01 before the card reports ready.
NAC_BYTES, 2, 0xFF bytes sent between the CMD17 R1 and the 0xFE start token.
BUSY_BYTES, 4, 0x00 busy bytes sent after a write data-response.

Ports:
clk  in  1  system clock; must be at least 8x spi_clk.
rst_n  in  1  asynchronous active-low reset.
spi_cs_n  in  1  chip select from host, active low.
spi_clk  in  1  SPI clock from host, mode 0.
spi_mosi  in  1  host to card data.
spi_miso  out  1  card to host data.
mem_addr  out  BLK_W+9  byte address: {block, byte index[8:0]}.
mem_rdata  in  8  read data, valid 1 clk after mem_addr.
mem_wdata  out  8  write data.
mem_we  out  1  one-clk write strobe.
card_ready  out  1  high after successful init (ACMD41 returned 0x00).
cmd_index  out  6  index of last accepted command.

Behaviour:
- Reset values: spi_miso=1, mem_we=0, mem_addr=0, mem_wdata=0, card_ready=0, cmd_index=0. FSM enters HUNT.
- Synchronization: spi_cs_n, spi_clk and spi_mosi pass through 2-flop synchronizers. MOSI is sampled on the synchronized spi_clk rising edge. MISO updates on the synchronized falling edge. Bytes are MSB first.
- spi_cs_n high resets the bit counter and forces spi_miso=1. If this happens mid-transaction, the FSM returns to HUNT and bytes already written stay committed.
- FSM states: HUNT, CMD_RX, NCR, RESP, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
- HUNT: a received byte with bits[7:6]=01 starts a frame and moves to CMD_RX. 0xFF bytes are ignored.
- CMD_RX: collects 5 more bytes (arg[31:0] MSB first, then crc byte). Then NCR: one 0xFF byte, then RESP.
- Command responses:
  - CMD0: R1=0x01; clears card_ready and the ACMD41 poll counter.
  - CMD8: R7 = 0x01, 0x00, 0x00, arg[11:8], arg[7:0].
  - CMD55: R1 = {7'b0, ~card_ready}; sets app flag for the next command only.
  - ACMD41: if the poll counter is below INIT_POLLS, increment it and return 0x01. Otherwise return 0x00 and set card_ready.
  - CMD58: R3 = R1, then OCR 0xC0FF8000 (CCS=1, block addressing).
  - CMD17/CMD24 when card_ready=0: R1=0x05 (idle + illegal), no data phase.
  - CMD17/CMD24 with arg >= 2^BLK_W: R1=0x40, no data phase.
  - Any other index, or ACMD41 without a preceding CMD55: R1 = 0x04 | idle bit.
- Read path, CMD17 valid: R1=0x00, then NAC_BYTES x 0xFF, then 0xFE token, then 512 bytes from mem_addr = {arg[BLK_W-1:0], i}, then 0xFF 0xFF, then HUNT. mem_addr is presented at least 2 clk before the byte is loaded into the shifter.
- Write path, CMD24 valid: R1=0x00. In WR_TOKEN, 0xFF bytes are ignored and 0xFE enters WR_DATA. Each received byte pulses mem_we for 1 clk with mem_addr={block,i}. The 2 CRC bytes are discarded. The card then sends data-response 0x05, then BUSY_BYTES x 0x00, then 0xFF, then HUNT.
- Frames arriving during RESP or the data phases are not decoded (no CMD12 support).
- Width rule: byte index is 9 bits and finishes after 511; block index is truncated to BLK_W bits after the range check.

Optional Feature:
SD_CRC7_CHECK_EN
- Defined: the responder computes CRC7 over the first 5 frame bytes and compares it with crc byte bits[7:1]. On mismatch it returns R1 = 0x08 | idle bit, does not execute the command, and does not update cmd_index.
- Undefined: the crc byte is ignored and all frames execute.

Test Plan:
- CMD0 arg 0x00000000, crc 0x95 -> host sees 0xFF then 0x01; card_ready=0; cmd_index=0.
- CMD8 arg 0x000001AA, crc 0x87 -> response 0x01 0x00 0x00 0x01 0xAA.
- INIT_POLLS=2, three CMD55+ACMD41 pairs -> ACMD41 R1 = 0x01, 0x01, 0x00; card_ready rises after the third. CMD58 -> 0x00 0xC0 0xFF 0x80 0x00.
- CMD24 arg 3, data byte i = i[7:0] -> 512 mem_we pulses at addresses 1536..2047, then 0x05 and 4 x 0x00. Follow with CMD17 arg 3 -> 0x00, 0xFF 0xFF, 0xFE, bytes 0x00..0xFF repeating, 0xFF 0xFF.
- CMD17 before init -> 0x05 with no token. CMD17 arg 16 with BLK_W=4 -> 0x40. CS raised after 100 read bytes -> spi_miso=1 within 3 clk; a following CMD0 returns 0x01.
- CMD0 with crc 0x00 -> 0x09 with SD_CRC7_CHECK_EN defined, 0x01 without it.
